rsa_input_loader: RTL and testbench
===================================

# rsa_input_loader

Byte-stream front end for the RSA exponentiation core. It accepts command frames from the host over a valid/ready byte interface and assembles the payload into a WIDTH-bit word. It then presents the word to the exponentiation controller together with a one-cycle `input_data_type` code (data, exponent e, or modulus n). While a data operation is in progress, it blocks further input until the controller reports `done`.

## Interface

Parameters:
- `WIDTH`, 32, operand width in bits; a multiple of 8 and at least 16. `BYTES = WIDTH/8` is derived.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `in_byte`  in  8  host byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `core_done`  in  1  one-cycle completion pulse from the controller's `done`.
- `input_data_type`  out  3  0 = none, 1 = data, 2 = e, 3 = n; to the controller.
- `word_out`  out  WIDTH  assembled operand; to the datapath operand/e/n registers.
- `busy`  out  1  high whenever the state is not IDLE.
- `err`  out  1  one-cycle pulse when a header is rejected.

## Operation

- **Handshake.** A byte transfers on a rising edge with `in_valid && in_ready`. Nothing else consumes a byte.
- **Frame format.** One header byte, then `BYTES` payload bytes, most-significant byte first.
  - Header 0x01 = data, 0x02 = e, 0x03 = n.
  - Any other header is dropped, `err` pulses in the following cycle, and the state stays IDLE.
- **State machine.**
  - **IDLE.** `in_ready=1`. A valid header latches the type code, clears the byte counter, and moves to PAYLOAD.
  - **PAYLOAD.** `in_ready=1`. Each accepted byte does `word_out <= {word_out[WIDTH-9:0], in_byte}` and increments the counter. When byte `BYTES` is accepted, move to ISSUE.
  - **ISSUE.** `in_ready=0`. `input_data_type` equals the latched code for exactly this cycle. Next state is WAIT_CORE for data, HOLD for e or n.
  - **HOLD.** `in_ready=0`. Lasts one cycle, covering the controller's UPDATE_E/UPDATE_N cycle so `word_out` is stable when the update happens. Then IDLE.
  - **WAIT_CORE.** `in_ready=0`. Stays here until `core_done=1`, then goes to IDLE.
- **`word_out` stability.** `word_out` changes only on accepted payload bytes. It is therefore stable from ISSUE through the end of HOLD or WAIT_CORE.
- **Output encoding.** `input_data_type` is 0 in every state other than ISSUE and is never X. `busy = (state != IDLE)`.
- **`core_done` outside WAIT_CORE.** Ignored, including in ISSUE.
- **Counter.** Width is `$clog2(BYTES)+1` bits; it cannot wrap within a frame.
- **Reset.** `rst_n` low at any point, including mid-payload or in WAIT_CORE, forces IDLE immediately, with:
  - `word_out=0`, `input_data_type=0`, `err=0`, counter 0, latched type 0;
  - `busy=0`, `in_ready=1` (IDLE decode).
  - A partial frame is discarded, and the next byte after release is treated as a header.

## Timing

- **Per-frame latency.** If the last payload byte is accepted at edge k, `input_data_type` is non-zero between edges k and k+1. The controller samples it at edge k+1.
- **e/n commands.** `in_ready` is low for 2 cycles (ISSUE, HOLD). The next header can be accepted at edge k+3.
- **Data commands.** `in_ready` stays low from ISSUE until `core_done` is sampled high at edge m. `in_ready` is high in the cycle after edge m.
- **Throughput.** Back-to-back bytes are accepted every cycle in IDLE and PAYLOAD. `in_valid` gaps insert idle cycles with no state change.
- **Output timing.**
  - `err`, `input_data_type` and `word_out` are registered outputs.
  - `in_ready` and `busy` are combinational decodes of the state register only, with no path from `in_valid`.

## Test plan

All scenarios use WIDTH=32.

1. **e load.** Send 0x02, 0x00, 0x01, 0x00, 0x01 on consecutive cycles. Expect `word_out`=0x00010001, `input_data_type`=2 for exactly 1 cycle, `in_ready` low for 2 cycles, then high.
2. **Data load with stall.** Send 0x01, 0xDE, 0xAD, 0xBE, 0xEF. Expect `input_data_type`=1 for 1 cycle. Hold `in_valid=1` with 0x03 for 20 cycles: no byte is accepted, and `word_out` stays 0xDEADBEEF. Pulse `core_done`: `in_ready`=1 the next cycle, and 0x03 is then taken as a header.
3. **Bad header.** Send 0x07. Expect `err` pulse for 1 cycle and no `input_data_type`. Then send 0x03, 0x12, 0x34, 0x56, 0x78: expect `input_data_type`=3 with `word_out`=0x12345678.
4. **`in_valid` gaps.** Send an e frame with 0–3 random idle cycles between bytes. Expect the correct word and exactly one type pulse.
5. **Reset mid-payload.** Assert `rst_n` low after 2 payload bytes. Expect all outputs at reset values immediately. After release, a full n frame loads correctly.
6. **Spurious `core_done`.** Pulse `core_done` in IDLE and in PAYLOAD. Expect no state change and no byte loss.

Source files
------------

// File: rtl/rsa_input_loader.sv
// rsa_input_loader: assembles host command frames into operands and hands them to the RSA exponentiation controller
module rsa_input_loader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             core_done,
  output logic [2:0]       input_data_type,
  output logic [WIDTH-1:0] word_out,
  output logic             busy,
  output logic             err
);
  localparam int BYTES = WIDTH / 8;
  localparam int CW = $clog2(BYTES) + 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
  typedef enum logic [2:0] {IDLE, PAYLOAD, ISSUE, HOLD, WAIT_CORE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0] type_q;
  logic acc, hdr_ok, last;
  assign acc = in_valid && in_ready;
  assign hdr_ok = in_byte == 8'h01 || in_byte == 8'h02 || in_byte == 8'h03;
  assign last = state == PAYLOAD && acc && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = acc && hdr_ok ? PAYLOAD : IDLE;
      PAYLOAD:   state_d = last ? ISSUE : PAYLOAD;
      ISSUE:     state_d = type_q == 3'd1 ? WAIT_CORE : HOLD;
      HOLD:      state_d = IDLE;
      WAIT_CORE: state_d = core_done ? IDLE : WAIT_CORE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE || state == PAYLOAD;
    busy = state != IDLE;
  end
  // type code is registered on the last payload byte so it is non-zero only while in ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      type_q <= '0;
      word_out <= '0;
      input_data_type <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && acc && hdr_ok) begin
        type_q <= in_byte[2:0];
        cnt <= '0;
      end
      if (state == PAYLOAD && acc) begin
        word_out <= {word_out[WIDTH-9:0], in_byte};
        cnt <= cnt + 1'b1;
      end
      input_data_type <= last ? type_q : 3'd0;
      err <= state == IDLE && acc && !hdr_ok;
    end
  end
endmodule

// File: tb/tb_rsa_input_loader.sv
// tb_rsa_input_loader: directed table-driven bench for rsa_input_loader at WIDTH=32
module tb_rsa_input_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] in_byte;
  logic in_valid, in_ready, core_done, busy, err;
  logic [2:0] input_data_type;
  logic [31:0] word_out;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int frames = 0;
  rsa_input_loader #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .core_done(core_done), .input_data_type(input_data_type), .word_out(word_out),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (input_data_type != 3'd0) pulses++;
  typedef struct {
    logic [7:0] hdr;
    logic [31:0] payload;
    int max_gap;
    logic [2:0] exp_type;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_byte = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected in_ready=1 byte %h", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] p, input int max_gap);
    send_byte(hdr);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(p[31-8*i -: 8]);
    end
  endtask
  // called at the negedge right after the last payload byte was accepted
  task automatic check_issue(input logic [2:0] t, input logic [31:0] w);
    frames++;
    chk("issue_type", 32'(input_data_type), 32'(t));
    chk("issue_word", word_out, w);
    chk("issue_ready", 32'(in_ready), 32'd0);
    chk("issue_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("post_type", 32'(input_data_type), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd0);
    chk("post_word", word_out, w);
    if (t == 3'd1) begin
      repeat (3) @(negedge clk);
      chk("wait_ready", 32'(in_ready), 32'd0);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
    end else begin
      @(negedge clk);
    end
    chk("back_ready", 32'(in_ready), 32'd1);
    chk("back_busy", 32'(busy), 32'd0);
  endtask
  initial begin
    vecs[0] = '{8'h02, 32'h00010001, 0, 3'd2};
    vecs[1] = '{8'h03, 32'h12345678, 0, 3'd3};
    vecs[2] = '{8'h02, 32'hCAFEF00D, 3, 3'd2};
    vecs[3] = '{8'h01, 32'hDEADBEEF, 0, 3'd1};
    vecs[4] = '{8'h03, 32'hFFFFFFFF, 2, 3'd3};
    vecs[5] = '{8'h02, 32'h00000000, 1, 3'd2};
    rst_n = 1'b0;
    in_byte = 8'h00;
    in_valid = 1'b0;
    core_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_word", word_out, 32'd0);
    chk("rst_type", 32'(input_data_type), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].hdr, vecs[i].payload, vecs[i].max_gap);
      check_issue(vecs[i].exp_type, vecs[i].payload);
    end
    send_frame(8'h01, 32'hDEADBEEF, 0);
    chk("stall_type", 32'(input_data_type), 32'd1);
    in_byte = 8'h03;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_word", word_out, 32'hDEADBEEF);
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("done_ready", 32'(in_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("hdr_after_done", 32'(busy), 32'd1);
    frames++;
    for (int i = 0; i < 4; i++) send_byte(8'(i + 5));
    check_issue(3'd3, 32'h05060708);
    send_byte(8'h07);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_type", 32'(input_data_type), 32'd0);
    @(negedge clk);
    chk("bad_err_clear", 32'(err), 32'd0);
    frames--;
    send_frame(8'h03, 32'h12345678, 0);
    check_issue(3'd3, 32'h12345678);
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_word", word_out, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_type", 32'(input_data_type), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'h03, 32'h01020304, 0);
    check_issue(3'd3, 32'h01020304);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("spur_idle_busy", 32'(busy), 32'd0);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    core_done = 1'b1;
    send_byte(8'h33);
    core_done = 1'b0;
    chk("spur_payload_busy", 32'(busy), 32'd1);
    send_byte(8'h44);
    check_issue(3'd2, 32'h11223344);
    repeat (2) @(negedge clk);
    chk("pulse_count", 32'(pulses), 32'(frames + 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
